msg_rr_arb: RTL and testbench

- Two-input round-robin message arbiter placed in front of a packet-out serializer.
- Accepts whole messages (address+data+redundancy) from two 4-phase req/ack input channels.
- Forwards one message at a time on a single 4-phase output channel.
- Alternates between inputs when both are pending, so neither starves the shared serializer.

---
 rtl/msg_rr_arb_pkg.sv | 46 ++++
 rtl/msg_rr_pick.sv | 23 ++
 rtl/msg_rr_arb.sv | 163 ++++++++++++++++
 tb/tb_msg_rr_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_rr_arb_pkg.sv
// ============================================================================
// Module : msg_rr_arb_pkg
// Brief  : Shared definitions for msg_rr_arb: field-size defaults, MSZ macro,
//          channel port macros and the arbiter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

`define MSG_ARB_MSZ(a, d, r) ((a) + (d) + (r))

// 4-phase channel port bundles: request, message, acknowledge
`define MSG_ARB_IN_CH(req_n, msg_n, ack_n, w) \
    input  logic req_n, \
    input  logic [(w)-1:0] msg_n, \
    output logic ack_n
`define MSG_ARB_OUT_CH(req_n, msg_n, ack_n, w) \
    output logic req_n, \
    output logic [(w)-1:0] msg_n, \
    input  logic ack_n

package msg_rr_arb_pkg;

    typedef enum logic [1:0] {
        MSG_ARB_IDLE  = 2'd0,
        MSG_ARB_XFER  = 2'd1,
        MSG_ARB_DRAIN = 2'd2
    } msg_arb_state_e;

    // A tie goes to the input that did not win last time.
    function automatic logic rr_pick_idx(input logic [1:0] pend, input logic lg);
        return (pend == 2'b11) ? ~lg : pend[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/msg_rr_pick.sv
// ============================================================================
// Module : msg_rr_pick
// Brief  : Combinational two-way round-robin pick from pending bits and the
//          last-grant pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msg_rr_pick
    import msg_rr_arb_pkg::*;
(
    input  logic [1:0] pend,
    input  logic       lg,
    output logic       grant_vld,
    output logic       grant_idx
);

    assign grant_vld = |pend;
    assign grant_idx = rr_pick_idx(pend, lg);

endmodule

`default_nettype wire

// File: rtl/msg_rr_arb.sv
// ============================================================================
// Module : msg_rr_arb
// Brief  : Two-input round-robin message arbiter, 4-phase req/ack on all
//          channels. Optional grant statistics: NS_MSG_RR_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msg_rr_arb
    import msg_rr_arb_pkg::*;
#(
    parameter  int ASZ   = `NS_ADDRESS_SIZE,
    parameter  int DSZ   = `NS_DATA_SIZE,
    parameter  int RSZ   = `NS_REDUN_SIZE,
    parameter  int CNT_W = 16,
    localparam int MSZ   = `MSG_ARB_MSZ(ASZ, DSZ, RSZ)
) (
    input  logic gch_clk,
    input  logic gch_reset,
    output logic gch_ready,
    `MSG_ARB_IN_CH(rcv0_req, rcv0_msg, rcv0_ack, MSZ),
    `MSG_ARB_IN_CH(rcv1_req, rcv1_msg, rcv1_ack, MSZ),
    `MSG_ARB_OUT_CH(snd0_req, snd0_msg, snd0_ack, MSZ)
`ifdef NS_MSG_RR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat0_cnt,
    output logic [CNT_W-1:0] stat1_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("msg_rr_arb: CNT_W must be at least 1");
    end

    msg_arb_state_e   state_q, state_d;
    logic             ready_q, ready_d;
    logic [1:0]       ack_q, ack_d;
    logic             snd_req_q, snd_req_d;
    logic [MSZ-1:0]   snd_msg_q, snd_msg_d;
    logic             lg_q, lg_d;
    logic             gsel_q, gsel_d;

    logic [1:0]       w_req;
    logic [1:0]       w_pend;
    logic             w_grant_vld;
    logic             w_grant_idx;
    logic             w_grant;

    assign w_req  = {rcv1_req, rcv0_req};
    assign w_pend = w_req & ~ack_q;

    msg_rr_pick u_pick (
        .pend      (w_pend),
        .lg        (lg_q),
        .grant_vld (w_grant_vld),
        .grant_idx (w_grant_idx)
    );

    assign w_grant = (state_q == MSG_ARB_IDLE) && ready_q && w_grant_vld;

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b1;
        ack_d     = ack_q;
        snd_req_d = snd_req_q;
        snd_msg_d = snd_msg_q;
        lg_d      = lg_q;
        gsel_d    = gsel_q;

        // Input release is independent of the transfer state.
        for (int k = 0; k < 2; k++) begin
            if (ack_q[k] && !w_req[k]) begin
                ack_d[k] = 1'b0;
            end
        end

        case (state_q)
            MSG_ARB_IDLE: begin
                if (w_grant) begin
                    snd_msg_d          = w_grant_idx ? rcv1_msg : rcv0_msg;
                    ack_d[w_grant_idx] = 1'b1;
                    snd_req_d          = 1'b1;
                    gsel_d             = w_grant_idx;
                    state_d            = MSG_ARB_XFER;
                end
            end
            MSG_ARB_XFER: begin
                if (snd0_ack) begin
                    snd_req_d = 1'b0;
                    state_d   = MSG_ARB_DRAIN;
                end
            end
            MSG_ARB_DRAIN: begin
                if (!snd0_ack) begin
                    lg_d    = gsel_q;
                    state_d = MSG_ARB_IDLE;
                end
            end
            default: begin
                state_d = MSG_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            state_q   <= MSG_ARB_IDLE;
            ready_q   <= 1'b0;
            ack_q     <= 2'b00;
            snd_req_q <= 1'b0;
            snd_msg_q <= '0;
            lg_q      <= 1'b1;
            gsel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            snd_req_q <= snd_req_d;
            snd_msg_q <= snd_msg_d;
            lg_q      <= lg_d;
            gsel_q    <= gsel_d;
        end
    end

    assign gch_ready = ready_q;
    assign rcv0_ack  = ack_q[0];
    assign rcv1_ack  = ack_q[1];
    assign snd0_req  = snd_req_q;
    assign snd0_msg  = snd_msg_q;

`ifdef NS_MSG_RR_ARB_STATS_EN
    logic [CNT_W-1:0] stat0_q, stat0_d;
    logic [CNT_W-1:0] stat1_q, stat1_d;

    // Saturating per-input grant counters.
    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (w_grant && !w_grant_idx && (stat0_q != {CNT_W{1'b1}})) begin
            stat0_d = stat0_q + CNT_W'(1);
        end
        if (w_grant && w_grant_idx && (stat1_q != {CNT_W{1'b1}})) begin
            stat1_d = stat1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_msg_rr_arb.sv
// ============================================================================
// Module : tb_msg_rr_arb
// Brief  : Self-checking bench for msg_rr_arb: directed scenarios plus
//          randomized handshakes against a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_msg_rr_arb;

    localparam int ASZ   = 4;
    localparam int DSZ   = 4;
    localparam int RSZ   = 4;
    localparam int MSZ   = ASZ + DSZ + RSZ;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           r0, r1, sack;
    logic [MSZ-1:0] m0, m1;
    logic           gready, a0, a1, sreq;
    logic [MSZ-1:0] smsg;
`ifdef NS_MSG_RR_ARB_STATS_EN
    logic [CNT_W-1:0] st0, st1;
`endif

    msg_rr_arb #(
        .ASZ   (ASZ),
        .DSZ   (DSZ),
        .RSZ   (RSZ),
        .CNT_W (CNT_W)
    ) dut (
        .gch_clk   (clk),
        .gch_reset (rst_n),
        .gch_ready (gready),
        .rcv0_req  (r0),
        .rcv0_msg  (m0),
        .rcv0_ack  (a0),
        .rcv1_req  (r1),
        .rcv1_msg  (m1),
        .rcv1_ack  (a1),
        .snd0_req  (sreq),
        .snd0_msg  (smsg),
        .snd0_ack  (sack)
`ifdef NS_MSG_RR_ARB_STATS_EN
        ,
        .stat0_cnt (st0),
        .stat1_cnt (st1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: one outstanding message, owner, who won last, counts.
    logic           e_ready;
    logic [1:0]     e_ack;
    logic           e_sreq;
    logic [MSZ-1:0] e_smsg;
    int             e_busy;   // 0 free, 1 waiting serializer ack, 2 waiting ack release
    int             e_owner;
    int             e_last;
    int             e_cnt[2];

    task automatic model_reset();
        e_ready = 1'b0; e_ack = 2'b00; e_sreq = 1'b0; e_smsg = '0;
        e_busy = 0; e_owner = 0; e_last = 1; e_cnt[0] = 0; e_cnt[1] = 0;
    endtask

    task automatic model_step();
        bit p0, p1, was_ready;
        int win;
        int busy_now;
        p0 = r0 && !e_ack[0];
        p1 = r1 && !e_ack[1];
        was_ready = e_ready;
        busy_now  = e_busy;
        e_ready = 1'b1;
        if (e_ack[0] && !r0) e_ack[0] = 1'b0;
        if (e_ack[1] && !r1) e_ack[1] = 1'b0;
        if (busy_now == 0) begin
            if (was_ready && (p0 || p1)) begin
                win = (p0 && p1) ? 1 - e_last : (p1 ? 1 : 0);
                e_ack[win] = 1'b1;
                e_sreq  = 1'b1;
                e_smsg  = (win == 1) ? m1 : m0;
                e_owner = win;
                e_busy  = 1;
                if (e_cnt[win] < CMAX) e_cnt[win]++;
            end
        end else if (busy_now == 1) begin
            if (sack) begin
                e_sreq = 1'b0;
                e_busy = 2;
            end
        end else begin
            if (!sack) begin
                e_last = e_owner;
                e_busy = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("ready", {31'd0, gready}, {31'd0, e_ready});
        check_eq("ack0",  {31'd0, a0},     {31'd0, e_ack[0]});
        check_eq("ack1",  {31'd0, a1},     {31'd0, e_ack[1]});
        check_eq("sreq",  {31'd0, sreq},   {31'd0, e_sreq});
        check_eq("smsg",  32'(smsg),       32'(e_smsg));
`ifdef NS_MSG_RR_ARB_STATS_EN
        check_eq("stat0", 32'(st0), 32'(e_cnt[0]));
        check_eq("stat1", 32'(st1), 32'(e_cnt[1]));
`endif
    endtask

    // Grant order observed on the DUT (rising input ack).
    int   dut_log[$];
    logic prev_a0 = 1'b0, prev_a1 = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        if (a1 === 1'b1 && !prev_a1) dut_log.push_back(1);
        else if (a0 === 1'b1 && !prev_a0) dut_log.push_back(0);
        prev_a0 = (a0 === 1'b1);
        prev_a1 = (a1 === 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        prev_a0 = 1'b0;
        prev_a1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reactive producers and serializer; rnd adds random delays.
    task automatic drive(input bit en0, input bit en1, input bit rnd);
        if (!r0 && !e_ack[0] && en0 && (!rnd || $urandom_range(0, 2) == 0)) begin
            r0 = 1'b1; m0 = MSZ'($urandom);
        end else if (r0 && e_ack[0] && (!rnd || $urandom_range(0, 1) == 0)) begin
            r0 = 1'b0;
        end
        if (!r1 && !e_ack[1] && en1 && (!rnd || $urandom_range(0, 2) == 0)) begin
            r1 = 1'b1; m1 = MSZ'($urandom);
        end else if (r1 && e_ack[1] && (!rnd || $urandom_range(0, 1) == 0)) begin
            r1 = 1'b0;
        end
        if (e_sreq && !sack && (!rnd || $urandom_range(0, 1) == 0)) begin
            sack = 1'b1;
        end else if (!e_sreq && sack && (!rnd || $urandom_range(0, 1) == 0)) begin
            sack = 1'b0;
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [MSZ-1:0] held;
        int cyc;
        rst_n = 1'b1;
        r0 = 1'b0; r1 = 1'b0; sack = 1'b0; m0 = '0; m1 = '0;
        #1;

        // First grant after reset release
        do_reset();
        r0 = 1'b1; m0 = MSZ'(12'h0A5);
        tick();
        check_eq("e1_ready", {31'd0, gready}, 32'd1);
        check_eq("e1_no_req", {31'd0, sreq}, 32'd0);
        tick();
        check_eq("g_sreq", {31'd0, sreq}, 32'd1);
        check_eq("g_smsg", 32'(smsg), 32'h0A5);
        check_eq("g_ack0", {31'd0, a0}, 32'd1);

        // Input 0 releases while its message is still in XFER
        r0 = 1'b0;
        tick();
        check_eq("rel0_ack", {31'd0, a0}, 32'd0);
        check_eq("rel0_sreq", {31'd0, sreq}, 32'd1);

        // Serializer stalls for 20 cycles; input 1 must wait
        r1 = 1'b1; m1 = MSZ'(12'h3C7);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("stall_sreq", {31'd0, sreq}, 32'd1);
            check_eq("stall_smsg", 32'(smsg), 32'h0A5);
            check_eq("stall_ack1", {31'd0, a1}, 32'd0);
        end
        sack = 1'b1; tick();
        check_eq("drain_sreq", {31'd0, sreq}, 32'd0);
        sack = 1'b0; tick();
        tick();
        check_eq("g1_ack1", {31'd0, a1}, 32'd1);
        check_eq("g1_smsg", 32'(smsg), 32'h3C7);

        // Input 1 drops req during XFER
        r1 = 1'b0;
        tick();
        check_eq("rel1_ack", {31'd0, a1}, 32'd0);
        check_eq("rel1_sreq", {31'd0, sreq}, 32'd1);
        sack = 1'b1; tick();
        sack = 1'b0; tick();
        tick();

        // Asynchronous reset in XFER, then a tie goes to input 0
        r0 = 1'b1; m0 = MSZ'(12'h111);
        tick();
        check_eq("ar_xfer", {31'd0, sreq}, 32'd1);
        r1 = 1'b1; m1 = MSZ'(12'h222);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_ready", {31'd0, gready}, 32'd0);
        check_eq("ar_sreq", {31'd0, sreq}, 32'd0);
        check_eq("ar_ack0", {31'd0, a0}, 32'd0);
        check_eq("ar_smsg", 32'(smsg), 32'd0);
        model_reset();
        prev_a0 = 1'b0; prev_a1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("tie_ack0", {31'd0, a0}, 32'd1);
        check_eq("tie_ack1", {31'd0, a1}, 32'd0);
        check_eq("tie_smsg", 32'(smsg), 32'h111);
        settle();

        // Both inputs requesting back-to-back: strict alternation
        do_reset();
        dut_log.delete();
        r0 = 1'b1; m0 = MSZ'($urandom);
        r1 = 1'b1; m1 = MSZ'($urandom);
        cyc = 0;
        while (dut_log.size() < 4 && cyc < 200) begin
            tick();
            if (dut_log.size() < 4) drive(1'b1, 1'b1, 1'b0);
            cyc++;
        end
        check_eq("alt_count", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < dut_log.size() && i < 4; i++) begin
            check_eq("alt_order", 32'(dut_log[i]), 32'(i % 2));
        end
`ifdef NS_MSG_RR_ARB_STATS_EN
        check_eq("alt_stat0", 32'(st0), 32'd2);
        check_eq("alt_stat1", 32'(st1), 32'd2);
`endif
        settle();

        // 17 grants to input 0: counter saturates
        do_reset();
        dut_log.delete();
        cyc = 0;
        while (dut_log.size() < 17 && cyc < 400) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
            cyc++;
        end
        check_eq("sat_grants", 32'(dut_log.size()), 32'd17);
`ifdef NS_MSG_RR_ARB_STATS_EN
        check_eq("sat_stat0", 32'(st0), 32'(CMAX));
        check_eq("sat_stat1", 32'(st1), 32'd0);
`endif
        settle();

        // Randomized traffic
        do_reset();
        held = '0;
        for (int i = 0; i < 3000; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            tick();
            if (sreq === 1'b1) held = smsg;
        end
        settle();
        check_eq("end_smsg_hold", 32'(smsg), 32'(e_smsg));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
